// File: rtl/sdram_port_arbiter.sv
// Two-port (I read-only, D read/write) arbiter for the 8-word SDRAM line interface; grant held for the whole line, mem_* registered (+1 cycle), x_done 1 cycle after mem_done.
// Non-owner requests wait until IDLE. Fixed priority D > I; `define SDRAM_ARB_RR_EN selects round-robin.
module sdram_port_arbiter #(
   parameter int ADDR_W      = 24,
   parameter int LINE_W      = 128,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [LINE_W-1:0] i_line,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_done,
   output logic [LINE_W-1:0] d_line,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic              mem_valid,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_done,
   input  logic              mem_init_done,
   output logic              busy,
   output logic              err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      RESP_I = 3'd3,
      RESP_D = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic               mem_wr_q, mem_wr_d;
   logic               mem_rd_q, mem_rd_d;
   logic               mem_valid_q, mem_valid_d;
   logic [LINE_W-1:0]  i_line_q, i_line_d;
   logic [LINE_W-1:0]  d_line_q, d_line_d;
   logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic               err_q, err_d;
   logic               pick_d;

`ifdef SDRAM_ARB_RR_EN
   // 1 = D was granted last; reset value favours D on the first contested grant.
   logic               last_grant_q, last_grant_d;
`endif

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wr_d    = mem_wr_q;
      mem_rd_d    = mem_rd_q;
      mem_valid_d = mem_valid_q;
      i_line_d    = i_line_q;
      d_line_d    = d_line_q;
      tmo_cnt_d   = tmo_cnt_q;
      pick_d      = 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_grant_d = last_grant_q;
      pick_d       = d_req && (!i_req || !last_grant_q);
`else
      pick_d       = d_req;
`endif

      case (state_q)
         IDLE: begin
            if (mem_init_done && (d_req || i_req)) begin
               mem_valid_d = 1'b1;
               tmo_cnt_d   = '0;
`ifdef SDRAM_ARB_RR_EN
               last_grant_d = pick_d;
`endif
               if (pick_d) begin
                  state_d     = BUSY_D;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  mem_wr_d    = d_wr;
                  mem_rd_d    = !d_wr;
               end else begin
                  state_d     = BUSY_I;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = '0;
                  mem_wr_d    = 1'b0;
                  mem_rd_d    = 1'b1;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (tmo_cnt_q != CNT_W'(TIMEOUT_CYC)) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            // Dropping valid at the done edge keeps the controller from relaunching.
            if (mem_done) begin
               if (mem_rd_q && state_q == BUSY_I) i_line_d = mem_rdata;
               if (mem_rd_q && state_q == BUSY_D) d_line_d = mem_rdata;
               mem_valid_d = 1'b0;
               mem_wr_d    = 1'b0;
               mem_rd_d    = 1'b0;
               state_d     = (state_q == BUSY_I) ? RESP_I : RESP_D;
            end
         end
         RESP_I, RESP_D: state_d = IDLE;
         default:        state_d = IDLE;
      endcase

      err_d = err_q || (tmo_cnt_d == CNT_W'(TIMEOUT_CYC));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_valid_q <= 1'b0;
         i_line_q    <= '0;
         d_line_q    <= '0;
         tmo_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
         mem_rd_q    <= mem_rd_d;
         mem_valid_q <= mem_valid_d;
         i_line_q    <= i_line_d;
         d_line_q    <= d_line_d;
         tmo_cnt_q   <= tmo_cnt_d;
         err_q       <= err_d;
      end
   end

`ifdef SDRAM_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign i_done      = (state_q == RESP_I);
   assign d_done      = (state_q == RESP_D);
   assign i_line      = i_line_q;
   assign d_line      = d_line_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_wr      = mem_wr_q;
   assign mem_rd      = mem_rd_q;
   assign mem_valid   = mem_valid_q;
   assign busy        = (state_q != IDLE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant gating, I read, D write, arbitration order, spurious done, timeout and async reset.
module tb_sdram_port_arbiter;

   localparam int ADDR_W = 24;
   localparam int LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_req = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic              i_done;
   logic [LINE_W-1:0] i_line;
   logic              d_req = 1'b0;
   logic              d_wr = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [LINE_W-1:0] d_wdata = '0;
   logic              d_done;
   logic [LINE_W-1:0] d_line;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic              mem_rd;
   logic              mem_valid;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata = '0;
   logic              mem_done = 1'b0;
   logic              mem_init_done = 1'b0;
   logic              busy;
   logic              err_timeout;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [LINE_W-1:0] LINE_BEEF = 128'hDEAD_0001_0002_0003_0004_0005_0006_BEEF;
   localparam logic [LINE_W-1:0] LINE_WR   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

   sdram_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYC(4096)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_line(i_line),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_line(d_line),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_valid(mem_valid),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .mem_init_done(mem_init_done), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One read transaction: grant edge, one busy cycle, then mem_done; leaves the bench in the RESP cycle.
   task automatic serve(input logic exp_d, input logic [ADDR_W-1:0] exp_addr,
                        input logic [LINE_W-1:0] rdata, input string tag);
      step;
      chk1({tag, "_valid"}, mem_valid, 1'b1);
      chkw({tag, "_addr"}, LINE_W'(mem_addr), LINE_W'(exp_addr));
      chk1({tag, "_rd"}, mem_rd, 1'b1);
      step;
      mem_rdata = rdata;
      mem_done  = 1'b1;
      step;
      mem_done  = 1'b0;
      chk1({tag, "_d_done"}, d_done, exp_d);
      chk1({tag, "_i_done"}, i_done, !exp_d);
      chkw({tag, "_line"}, exp_d ? d_line : i_line, rdata);
   endtask

   initial begin
      // Reset state
      #12;
      chk1("rst_valid", mem_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_i_done", i_done, 1'b0);
      chk1("rst_d_done", d_done, 1'b0);
      chk1("rst_err", err_timeout, 1'b0);
      chkw("rst_i_line", i_line, '0);
      chkw("rst_d_line", d_line, '0);
      step;
      rst_n = 1'b1;
      step;

      // No grant before SDRAM init completes
      i_req  = 1'b1;
      i_addr = 24'h000100;
      for (int k = 0; k < 20; k++) begin
         step;
         chk1("noinit_valid", mem_valid, 1'b0);
      end
      chk1("noinit_busy", busy, 1'b0);
      mem_init_done = 1'b1;
      step;
      chk1("i_valid", mem_valid, 1'b1);
      chkw("i_addr", LINE_W'(mem_addr), LINE_W'(24'h000100));
      chk1("i_rd", mem_rd, 1'b1);
      chk1("i_wr", mem_wr, 1'b0);
      chk1("i_busy", busy, 1'b1);
      step;
      step;
      step;
      chk1("i_no_early_done", i_done, 1'b0);
      mem_rdata = LINE_BEEF;
      mem_done  = 1'b1;
      step;
      mem_done  = 1'b0;
      chk1("i_done", i_done, 1'b1);
      chk1("i_d_done", d_done, 1'b0);
      chkw("i_line", i_line, LINE_BEEF);
      chk1("i_valid_low", mem_valid, 1'b0);
      chk1("i_rd_low", mem_rd, 1'b0);
      i_req = 1'b0;
      step;
      chk1("i_done_pulse", i_done, 1'b0);
      chk1("i_idle", busy, 1'b0);

      // D write
      d_req   = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 24'h000010;
      d_wdata = LINE_WR;
      step;
      chk1("dw_valid", mem_valid, 1'b1);
      chk1("dw_wr", mem_wr, 1'b1);
      chk1("dw_rd", mem_rd, 1'b0);
      chkw("dw_addr", LINE_W'(mem_addr), LINE_W'(24'h000010));
      chkw("dw_wdata", mem_wdata, LINE_WR);
      for (int k = 0; k < 11; k++) begin
         step;
         chk1("dw_wait_done", d_done, 1'b0);
      end
      chkw("dw_wdata_held", mem_wdata, LINE_WR);
      mem_rdata = '1;
      mem_done  = 1'b1;
      step;
      mem_done  = 1'b0;
      chk1("dw_d_done", d_done, 1'b1);
      chk1("dw_i_done", i_done, 1'b0);
      chkw("dw_d_line", d_line, '0);
      chk1("dw_valid_low", mem_valid, 1'b0);
      chk1("dw_wr_low", mem_wr, 1'b0);
      d_req = 1'b0;
      d_wr  = 1'b0;
      step;
      chk1("dw_done_pulse", d_done, 1'b0);

      // Spurious mem_done while idle
      mem_done = 1'b1;
      step;
      mem_done = 1'b0;
      chk1("sp_i_done", i_done, 1'b0);
      chk1("sp_d_done", d_done, 1'b0);
      chk1("sp_busy", busy, 1'b0);
      chk1("sp_valid", mem_valid, 1'b0);
      step;
      chk1("sp_busy2", busy, 1'b0);
      chkw("sp_i_line", i_line, LINE_BEEF);

      // Contested requests, D reasserted immediately
      d_addr = 24'h000020;
      i_addr = 24'h000030;
      d_req  = 1'b1;
      i_req  = 1'b1;
      serve(1'b1, 24'h000020, 128'h1111, "arb1");
      step;
`ifdef SDRAM_ARB_RR_EN
      serve(1'b0, 24'h000030, 128'h2222, "arb2");
      i_req = 1'b0;
      step;
      serve(1'b1, 24'h000020, 128'h3333, "arb3");
`else
      serve(1'b1, 24'h000020, 128'h2222, "arb2");
      d_req = 1'b0;
      step;
      serve(1'b0, 24'h000030, 128'h3333, "arb3");
`endif
      d_req = 1'b0;
      i_req = 1'b0;
      step;
      chk1("arb_idle", busy, 1'b0);

      // Timeout: never answer
      i_req  = 1'b1;
      i_addr = 24'h000040;
      step;
      chk1("to_busy", busy, 1'b1);
      for (int k = 0; k < 4095; k++) step;
      chk1("to_err_before", err_timeout, 1'b0);
      step;
      chk1("to_err", err_timeout, 1'b1);
      chk1("to_busy_held", busy, 1'b1);
      step;
      chk1("to_err_sticky", err_timeout, 1'b1);

      // Asynchronous reset mid-transaction
      #2;
      rst_n = 1'b0;
      #1;
      chk1("ar_busy", busy, 1'b0);
      chk1("ar_valid", mem_valid, 1'b0);
      chk1("ar_rd", mem_rd, 1'b0);
      chk1("ar_wr", mem_wr, 1'b0);
      chk1("ar_err", err_timeout, 1'b0);
      chkw("ar_addr", LINE_W'(mem_addr), '0);
      chkw("ar_wdata", mem_wdata, '0);
      chkw("ar_i_line", i_line, '0);
      chkw("ar_d_line", d_line, '0);
      i_req = 1'b0;
      step;
      rst_n = 1'b1;
      step;
      chk1("ar_idle_after", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 8-word SDRAM line interface between two requesters: the instruction-fetch port (I, read-only) and the data port (D, read/write).
- Sits between the core's cache-refill logic and the SDRAM controller top.
- Grants one requester at a time, holds the grant for the whole line transaction, registers the downstream command, and routes the returned line and done pulse back to the owner.

Parameters:
- ADDR_W, 24, line address width (word address into SDRAM).
- LINE_W, 128, line width; 8 x 16-bit words, w0 in bits [15:0].
- TIMEOUT_CYC, 4096, busy cycles before the sticky timeout error sets.

Ports:
- clk  in  1  system clock (the 50 MHz user-side clock of the SDRAM block).
- rst_n  in  1  reset.
- i_req  in  1  I-port line read request; held until i_done.
- i_addr  in  ADDR_W  I-port line address; stable while i_req.
- i_done  out  1  one-cycle completion pulse to I.
- i_line  out  LINE_W  line returned to I; valid when i_done.
- d_req  in  1  D-port request; held until d_done.
- d_wr  in  1  1 = write line, 0 = read line; stable while d_req.
- d_addr  in  ADDR_W  D-port line address.
- d_wdata  in  LINE_W  D-port write line.
- d_done  out  1  one-cycle completion pulse to D.
- d_line  out  LINE_W  line returned to D on read.
- mem_addr  out  ADDR_W  downstream address.
- mem_wr  out  1  downstream write strobe.
- mem_rd  out  1  downstream read strobe.
- mem_valid  out  1  downstream valid.
- mem_wdata  out  LINE_W  downstream write line.
- mem_rdata  in  LINE_W  downstream read line.
- mem_done  in  1  downstream one-cycle done.
- mem_init_done  in  1  SDRAM initialisation complete.
- busy  out  1  arbiter not IDLE.
- err_timeout  out  1  sticky timeout flag.

Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values: all outputs 0; i_line and d_line are 0; state IDLE; internal registers cleared. Reset mid-transaction abandons it; the downstream controller shares rst_n.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Grants only when mem_init_done = 1.
  - If d_req, go to BUSY_D; else if i_req, go to BUSY_I. Fixed priority D > I.
  - On the grant edge, register mem_addr and mem_wdata from the winner. Set mem_wr = d_wr for D and 0 for I, and mem_rd = the inverse. Set mem_valid = 1.
- BUSY_x:
  - mem_* held constant.
  - On mem_done = 1: capture mem_rdata into x_line (reads only; on writes x_line holds its value), clear mem_valid/mem_wr/mem_rd at the same edge, go to RESP_x.
  - mem_valid is therefore low in the cycle after the downstream DONE, so the downstream IDLE state never re-launches.
- RESP_x: x_done = 1 for exactly this cycle, then IDLE.
  - The requester drops x_req at the edge where it samples x_done = 1.
  - Back-to-back requests are re-arbitrated in IDLE.
- Latency: req high in IDLE → mem_valid high 1 cycle later → x_done 1 cycle after mem_done. Minimum overhead is 2 cycles plus the downstream latency.
- Requests arriving while BUSY wait. The non-owner's req is ignored until IDLE; grant is never pre-empted.
- mem_done received in IDLE or RESP is ignored. No done pulse is generated and no state changes.
- mem_init_done dropping while BUSY has no effect on the current transaction.
- busy = (state != IDLE).
- Timeout counter:
  - Clears on each grant and increments every BUSY cycle, saturating.
  - When it reaches TIMEOUT_CYC, err_timeout sets and stays set until reset. The transaction is not aborted.

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset = I) is updated on each grant. When both requests are pending in IDLE, the port not granted last wins. A single request is granted immediately.
- Undefined: fixed priority D > I as above, and no last_grant register.

Test Plan:
- Hold mem_init_done = 0 with i_req = 1 for 20 cycles → mem_valid stays 0. Raise init → mem_valid = 1 next cycle with mem_addr = i_addr and mem_rd = 1.
- D write to 0x000010 with d_wdata = 0x0007_0006_..._0000, mem_done after 12 cycles → mem_wr = 1 and mem_wdata matches; d_done pulses 1 cycle after mem_done; d_line unchanged; i_done stays 0.
- I read of 0x000100, mem_rdata = 0xDEAD...BEEF → i_line = 0xDEAD...BEEF with i_done one cycle; mem_valid = 0 in the cycle after mem_done.
- Both req asserted together, back to back:
  - Without macro: D served twice before I while d_req is reasserted immediately.
  - With SDRAM_ARB_RR_EN: order is D, I, D.
- Never assert mem_done → err_timeout = 1 at cycle TIMEOUT_CYC (4096) of BUSY, busy stays 1. Assert rst_n = 0 → all outputs 0 and state IDLE immediately (asynchronous).
- Spurious mem_done pulse in IDLE → no i_done/d_done and no state change.
